// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register
// scoreboard.
//
// Purpose:
//   Holds NUM_REGS registers of DATA_W bits. Register 0 always reads as zero.
//   The block has two combinational read ports, one debug read port and one
//   synchronous writeback port. Each register also has a busy bit. Issue sets
//   the busy bit to reserve a destination, and writeback clears it. A
//   registered counter tracks how many registers are busy. A combinational
//   stall flags RAW hazards on used sources and WAW hazards on the reserve
//   target.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a writeback is forwarded to any read
//   or debug port that addresses the same register in the same cycle.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_rs1_addr/i_rs2_addr        source read addresses
//   i_rs1_used/i_rs2_used        issuing instruction consumes rs1/rs2
//   o_rs1_data/o_rs2_data        source read data (combinational)
//   o_rs1_busy/o_rs2_busy        source has a pending producer
//   i_rsv_valid/i_rsv_addr       reserve a destination register
//   o_stall                      RAW/WAW issue hazard
//   i_rd_wren/i_rd_addr/i_rd_data  writeback (also releases busy)
//   i_dbg_addr/o_dbg_data        debug read port (combinational)
//   o_busy_cnt                   number of busy registers (registered)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  input  logic              i_rsv_valid,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_stall,
  input  logic              i_rd_wren,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [ADDR_W:0]   o_busy_cnt
);

  // Storage covers the whole address space, so every address indexes the
  // arrays directly. Entries at 0 and at or above NUM_REGS are tied to zero.
  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NUM_REGS_W);
  endfunction

  logic [DATA_W-1:0] reg_data [DEPTH];
  logic [DEPTH-1:0]  reg_busy;

  logic wr_ok;
  logic rsv_ok;
  logic same_wr_rsv;

  assign wr_ok       = i_rd_wren && addr_ok(i_rd_addr);
  assign rsv_ok      = i_rsv_valid && addr_ok(i_rsv_addr);
  assign same_wr_rsv = wr_ok && rsv_ok && (i_rd_addr == i_rsv_addr);

  // ------------------------------------------------------------------
  // Register and busy-bit storage
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0 || gi >= NUM_REGS) begin : g_zero
        assign reg_data[gi] = '0;
        assign reg_busy[gi] = 1'b0;
      end else begin : g_live
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic [DATA_W-1:0] data_reg;
        logic              busy_reg;
        logic              wr_hit;
        logic              rsv_hit;

        assign wr_hit  = wr_ok && (i_rd_addr == IDX);
        assign rsv_hit = rsv_ok && (i_rsv_addr == IDX);

        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_hit) begin
              data_reg <= i_rd_data;
            end
            // A reserve in the same cycle as the writeback is a new producer,
            // so it overrides the release.
            if (rsv_hit) begin
              busy_reg <= 1'b1;
            end else if (wr_hit) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign reg_data[gi] = data_reg;
        assign reg_busy[gi] = busy_reg;
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Read ports: 0 = rs1, 1 = rs2, 2 = debug
  // ------------------------------------------------------------------
  logic [ADDR_W-1:0] port_addr [3];
  logic [DATA_W-1:0] port_data [3];
  logic [2:0]        port_busy;

  assign port_addr[0] = i_rs1_addr;
  assign port_addr[1] = i_rs2_addr;
  assign port_addr[2] = i_dbg_addr;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_port
      logic port_ok;
      assign port_ok = addr_ok(port_addr[gi]);
`ifdef REGFILE_BYPASS_EN
      // A writeback to this address shows up in the same cycle. Busy stays
      // set only if the same register is also being re-reserved now.
      logic fwd;
      assign fwd = wr_ok && (i_rd_addr == port_addr[gi]);
      assign port_data[gi] = fwd ? i_rd_data
                                 : (port_ok ? reg_data[port_addr[gi]] : '0);
      assign port_busy[gi] = fwd ? (rsv_ok && (i_rsv_addr == port_addr[gi]))
                                 : (port_ok && reg_busy[port_addr[gi]]);
`else
      assign port_data[gi] = port_ok ? reg_data[port_addr[gi]] : '0;
      assign port_busy[gi] = port_ok && reg_busy[port_addr[gi]];
`endif
    end
  endgenerate

  assign o_rs1_data = port_data[0];
  assign o_rs2_data = port_data[1];
  assign o_dbg_data = port_data[2];
  assign o_rs1_busy = port_busy[0];
  assign o_rs2_busy = port_busy[1];

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  // WAW: the reserve target already has an outstanding producer. With
  // forwarding, a same-cycle writeback to the target retires that producer.
  logic rsv_busy;
`ifdef REGFILE_BYPASS_EN
  assign rsv_busy = rsv_ok && reg_busy[i_rsv_addr] &&
                    !(wr_ok && (i_rd_addr == i_rsv_addr));
`else
  assign rsv_busy = rsv_ok && reg_busy[i_rsv_addr];
`endif

  assign o_stall = (i_rs1_used && port_busy[0]) ||
                   (i_rs2_used && port_busy[1]) ||
                   (i_rsv_valid && rsv_busy);

  // ------------------------------------------------------------------
  // Busy counter: tracks popcount(busy) incrementally
  // ------------------------------------------------------------------
  logic            set_new;
  logic            clr_old;
  logic [ADDR_W:0] busy_cnt_reg;
  logic [ADDR_W:0] busy_cnt_next;

  assign set_new = rsv_ok && !reg_busy[i_rsv_addr];
  // Releasing a register that is re-reserved in the same cycle leaves it
  // busy, so that case does not count as a release.
  assign clr_old = wr_ok && reg_busy[i_rd_addr] && !same_wr_rsv;

  assign busy_cnt_next = busy_cnt_reg + (ADDR_W+1)'(set_new)
                                      - (ADDR_W+1)'(clr_old);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cnt_reg <= '0;
    end else begin
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign o_busy_cnt = busy_cnt_reg;

endmodule
